// File: rtl/cycle_config_scheduler_if.sv
// Host/backend signal bundle for cycle_config_scheduler.
// The master modport is the host/backend side; the slave modport is the scheduler itself.
interface cycle_config_scheduler_if #(
  parameter int NUM_CHANNELS = 4
);
  logic                    shadow_we;
  logic [3:0]              shadow_addr;
  logic [15:0]             shadow_data;
  logic                    shadow_err;
  logic [NUM_CHANNELS-1:0] run_enable;
  logic                    commit_valid;
  logic [NUM_CHANNELS-1:0] commit_mask;
  logic                    commit_ready;
  logic                    commit_done;
  logic                    busy;
  logic [NUM_CHANNELS-1:0] update_cycle_complete;
  logic [NUM_CHANNELS-1:0] timer_enable;
  logic [NUM_CHANNELS-1:0] write_config_n;
  logic [5:0]              config_address;
  logic [15:0]             config_data;

  modport master (
    output shadow_we, shadow_addr, shadow_data, run_enable, commit_valid, commit_mask,
           update_cycle_complete,
    input  shadow_err, commit_ready, commit_done, busy, timer_enable, write_config_n,
           config_address, config_data
  );

  modport slave (
    input  shadow_we, shadow_addr, shadow_data, run_enable, commit_valid, commit_mask,
           update_cycle_complete,
    output shadow_err, commit_ready, commit_done, busy, timer_enable, write_config_n,
           config_address, config_data
  );
endinterface

// File: rtl/cycle_config_scheduler.sv
// Streams a 10-word shadow profile into the masked cycle controllers, halting their timers meanwhile.
// Define CFG_SYNC_COMMIT_EN to wait for each target's update_cycle_complete before halting it.
module cycle_config_scheduler #(
  parameter int NUM_CHANNELS = 4,
  parameter int CFG_WORDS    = 10
) (
  input logic                    clock,
  input logic                    reset_n,
  cycle_config_scheduler_if.slave bus
);
  localparam logic [3:0] LAST_WORD = 4'(CFG_WORDS - 1);

  typedef enum logic [2:0] {IDLE, WAIT_SYNC, HALT, WRITE, RESUME} state_t;

  state_t                  state, state_d;
  logic [NUM_CHANNELS-1:0] tgt, tgt_d, halted;
  logic [3:0]              cnt, cnt_d;
  logic [15:0]             shadow [CFG_WORDS];
  logic                    shadow_ok;

  assign bus.busy        = (state != IDLE);
  assign bus.commit_done = (state == RESUME);
  assign shadow_ok       = bus.shadow_we && !bus.busy && (bus.shadow_addr <= LAST_WORD);

  // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    state_d = state;
    tgt_d   = tgt;
    cnt_d   = cnt;
    case (state)
      IDLE: begin
        if (bus.commit_valid && bus.commit_ready) begin
          tgt_d = bus.commit_mask;
          if (bus.commit_mask == '0) begin
            state_d = RESUME;
          end else begin
`ifdef CFG_SYNC_COMMIT_EN
            state_d = WAIT_SYNC;
`else
            state_d = HALT;
`endif
          end
        end
      end
`ifdef CFG_SYNC_COMMIT_EN
      // A channel whose timer is already stopped has nothing to interrupt.
      WAIT_SYNC: begin
        if ((tgt & ~(bus.update_cycle_complete | ~bus.timer_enable)) == '0) state_d = HALT;
      end
`endif
      HALT: begin
        cnt_d   = '0;
        state_d = WRITE;
      end
      WRITE: begin
        if (cnt == LAST_WORD) state_d = RESUME;
        else                  cnt_d   = cnt + 4'd1;
      end
      RESUME:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Outputs are registered from next-state values so they line up with the state they belong to.
    halted = (state_d == HALT || state_d == WRITE) ? tgt_d : '0;
  end

`ifndef CFG_SYNC_COMMIT_EN
  // update_cycle_complete has no role without the sync stage.
  logic unused_sync;
  assign unused_sync = ^bus.update_cycle_complete;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state              <= IDLE;
      tgt                <= '0;
      cnt                <= '0;
      bus.commit_ready   <= 1'b0;
      bus.timer_enable   <= '0;
      bus.write_config_n <= '1;
      bus.config_address <= '0;
      bus.config_data    <= '0;
      bus.shadow_err     <= 1'b0;
      // NOTE: the shadow profile is reset because the host may commit before writing every word.
      for (int i = 0; i < CFG_WORDS; i++) shadow[i] <= '0;
    end else begin
      state            <= state_d;
      tgt              <= tgt_d;
      cnt              <= cnt_d;
      bus.commit_ready <= (state_d == IDLE);
      bus.timer_enable <= bus.run_enable & ~halted;
      if (state_d == WRITE) begin
        bus.write_config_n <= ~tgt_d;
        bus.config_address <= {2'b00, cnt_d};
        bus.config_data    <= shadow[cnt_d];
      end else begin
        bus.write_config_n <= '1;
      end
      if (shadow_ok)                     shadow[bus.shadow_addr] <= bus.shadow_data;
      else if (bus.shadow_we)            bus.shadow_err          <= 1'b1;
    end
  end
endmodule

// File: tb/tb_cycle_config_scheduler.sv
// Self-checking bench for cycle_config_scheduler: directed table, corner sequences, random commits.
// Honours CFG_SYNC_COMMIT_EN the same way as the design.
module tb_cycle_config_scheduler;
  localparam int NC = 4;
`ifdef CFG_SYNC_COMMIT_EN
  localparam int WS = 1;
`else
  localparam int WS = 0;
`endif

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  cycle_config_scheduler_if #(.NUM_CHANNELS(NC)) bus ();
  cycle_config_scheduler #(.NUM_CHANNELS(NC), .CFG_WORDS(10)) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus)
  );

  typedef struct {
    logic [3:0]  wcn;
    logic [3:0]  te;
    logic [5:0]  addr;
    logic [15:0] data;
    logic        done;
    logic        ready;
  } vec_t;

  int checks = 0;
  int errors = 0;

  logic [15:0] shadow_m [10];
  logic        err_m;
  logic [5:0]  last_addr;
  logic [15:0] last_data;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 10; i++) shadow_m[i] = '0;
    err_m     = 1'b0;
    last_addr = '0;
    last_data = '0;
  endtask

  task automatic check_out(input string tag, input logic [3:0] wcn, input logic [3:0] te,
                           input logic e_busy, input logic done, input logic ready);
    check($sformatf("%s.wcn", tag),   bus.write_config_n, wcn);
    check($sformatf("%s.te", tag),    bus.timer_enable,   te);
    check($sformatf("%s.busy", tag),  bus.busy,           e_busy);
    check($sformatf("%s.done", tag),  bus.commit_done,    done);
    check($sformatf("%s.ready", tag), bus.commit_ready,   ready);
    check($sformatf("%s.addr", tag),  bus.config_address, last_addr);
    check($sformatf("%s.data", tag),  bus.config_data,    last_data);
    check($sformatf("%s.err", tag),   bus.shadow_err,     err_m);
  endtask

  task automatic idle_write(input logic [3:0] addr, input logic [15:0] data);
    bus.shadow_we = 1'b1; bus.shadow_addr = addr; bus.shadow_data = data;
    step();
    bus.shadow_we = 1'b0;
    if (addr <= 4'd9) shadow_m[addr] = data;
    else              err_m = 1'b1;
  endtask

  // Reference timeline of one commit, derived from the phase durations; starts in IDLE with
  // run_enable already applied. stall>0 holds the targets' update_cycle_complete low that long.
  task automatic run_commit(input string tag, input logic [3:0] mask, input logic [3:0] run,
                            input logic acc_we, input logic [3:0] acc_addr,
                            input logic [15:0] acc_data, input int busy_wr_k, input int stall);
    int ws, last, w;
    logic [3:0] e_wcn, e_te;
    logic e_busy, e_done, e_ready, pend_err;
    ws   = (mask == 0) ? 0 : ((stall > 0 && (mask & run) != 0) ? stall : WS);
    last = (mask == 0) ? 2 : ws + 13;
    bus.update_cycle_complete = (stall > 0 && mask != 0) ? ~mask : '1;
    bus.commit_valid = 1'b1; bus.commit_mask = mask;
    bus.shadow_we = acc_we; bus.shadow_addr = acc_addr; bus.shadow_data = acc_data;
    step();
    bus.commit_valid = 1'b0; bus.shadow_we = 1'b0;
    if (acc_we) begin
      if (acc_addr <= 4'd9) shadow_m[acc_addr] = acc_data;
      else                  err_m = 1'b1;
    end
    for (int k = 1; k <= last; k++) begin
      e_wcn = '1; e_te = run; e_busy = 1'b1; e_done = 1'b0; e_ready = 1'b0;
      if (mask == 0) begin
        if (k == 1) e_done = 1'b1;
        else begin e_busy = 1'b0; e_ready = 1'b1; end
      end else if (k <= ws) begin
        e_te = run;
      end else if (k == ws + 1) begin
        e_te = run & ~mask;
      end else if (k <= ws + 11) begin
        w = k - ws - 2;
        e_wcn = ~mask; e_te = run & ~mask;
        last_addr = 6'(w); last_data = shadow_m[w];
      end else if (k == ws + 12) begin
        e_done = 1'b1;
      end else begin
        e_busy = 1'b0; e_ready = 1'b1;
      end
      check_out($sformatf("%s.k%0d", tag, k), e_wcn, e_te, e_busy, e_done, e_ready);
      if (k < last) begin
        pend_err = 1'b0;
        if (k == stall) bus.update_cycle_complete = '1;
        if (k == busy_wr_k) begin
          bus.shadow_we = 1'b1; bus.shadow_addr = 4'($urandom_range(0, 9));
          bus.shadow_data = 16'($urandom); pend_err = 1'b1;
        end
        step();
        bus.shadow_we = 1'b0;
        if (pend_err) err_m = 1'b1;
      end
    end
    bus.update_cycle_complete = '1;
  endtask

  vec_t tbl[$];
  int   nwr;

  initial begin
    bus.shadow_we = 1'b0; bus.shadow_addr = '0; bus.shadow_data = '0;
    bus.run_enable = '0; bus.commit_valid = 1'b0; bus.commit_mask = '0;
    bus.update_cycle_complete = '1;
    model_reset();

    // Reset values, then first idle cycle.
    repeat (3) step();
    check_out("reset", 4'hF, 4'h0, 1'b0, 1'b0, 1'b0);
    reset_n = 1'b1;
    step();
    check_out("idle", 4'hF, 4'h0, 1'b0, 1'b0, 1'b1);

    // Directed profile: words 0x1000+i, mask 0101, all runs on.
    for (int i = 0; i < WS; i++) tbl.push_back('{4'hF, 4'hF, 6'd0, 16'h0000, 1'b0, 1'b0});
    tbl.push_back('{4'hF, 4'b1010, 6'd0, 16'h0000, 1'b0, 1'b0});
    for (int i = 0; i < 10; i++) tbl.push_back('{4'b1010, 4'b1010, 6'(i), 16'h1000 + 16'(i), 1'b0, 1'b0});
    tbl.push_back('{4'hF, 4'hF, 6'd9, 16'h1009, 1'b1, 1'b0});
    tbl.push_back('{4'hF, 4'hF, 6'd9, 16'h1009, 1'b0, 1'b1});
    for (int i = 0; i < 10; i++) idle_write(4'(i), 16'h1000 + 16'(i));
    bus.run_enable = 4'hF;
    step();
    check("tbl.pre_te", bus.timer_enable, 4'hF);
    bus.commit_valid = 1'b1; bus.commit_mask = 4'b0101;
    step();
    bus.commit_valid = 1'b0;
    nwr = 0;
    for (int i = 0; i < tbl.size(); i++) begin
      check($sformatf("tbl%0d.wcn", i),   bus.write_config_n, tbl[i].wcn);
      check($sformatf("tbl%0d.te", i),    bus.timer_enable,   tbl[i].te);
      check($sformatf("tbl%0d.addr", i),  bus.config_address, tbl[i].addr);
      check($sformatf("tbl%0d.data", i),  bus.config_data,    tbl[i].data);
      check($sformatf("tbl%0d.done", i),  bus.commit_done,    tbl[i].done);
      check($sformatf("tbl%0d.ready", i), bus.commit_ready,   tbl[i].ready);
      if (bus.write_config_n == 4'b1010) nwr++;
      if (i < tbl.size() - 1) step();
    end
    check("tbl.write_cycles", nwr, 10);
    last_addr = 6'd9; last_data = 16'h1009;

    // Empty mask: done at T+1, ready at T+2, no write strobes.
    run_commit("mask0", 4'b0000, 4'hF, 1'b0, 4'd0, 16'd0, 0, 0);

`ifdef CFG_SYNC_COMMIT_EN
    // Channel 0 not yet at its update boundary for 20 cycles.
    run_commit("sync", 4'b0001, 4'hF, 1'b0, 4'd0, 16'd0, 0, 20);
`endif

    // Dropped writes: out-of-range address in IDLE, then a write during WRITE.
    idle_write(4'd12, 16'hDEAD);
    check("err.addr12", bus.shadow_err, 1'b1);
    run_commit("errwr", 4'b1111, 4'hF, 1'b0, 4'd0, 16'd0, WS + 5, 0);
    run_commit("errchk", 4'b0110, 4'hF, 1'b0, 4'd0, 16'd0, 0, 0);

    // Randomised commits against the timeline model.
    for (int n = 0; n < 40; n++) begin
      logic [3:0] run, mask;
      int st;
      for (int j = 0; j < $urandom_range(0, 3); j++)
        idle_write(4'($urandom_range(0, 10)), 16'($urandom));
      run = 4'($urandom);
      bus.run_enable = run;
      step();
      check($sformatf("rnd%0d.idle_te", n), bus.timer_enable, run);
      mask = ($urandom_range(0, 7) == 0) ? 4'b0000 : 4'($urandom);
`ifdef CFG_SYNC_COMMIT_EN
      st = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 4) : 0;
`else
      st = 0;
`endif
      run_commit($sformatf("rnd%0d", n), mask, run, 1'($urandom_range(0, 1)),
                 4'($urandom_range(0, 11)), 16'($urandom),
                 ($urandom_range(0, 3) == 0) ? $urandom_range(1, 14) : 0, st);
    end

    // Reset during the 5th WRITE cycle abandons the profile.
    bus.run_enable = 4'hF;
    step();
    bus.commit_valid = 1'b1; bus.commit_mask = 4'b0011;
    step();
    bus.commit_valid = 1'b0;
    repeat (WS + 5) step();
    check("rstw.in_write_wcn", bus.write_config_n, 4'b1100);
    check("rstw.in_write_addr", bus.config_address, 6'd4);
    reset_n = 1'b0;
    step();
    model_reset();
    check_out("rstw.reset", 4'hF, 4'h0, 1'b0, 1'b0, 1'b0);
    reset_n = 1'b1;
    step();
    check_out("rstw.idle", 4'hF, 4'hF, 1'b0, 1'b0, 1'b1);
    idle_write(4'd3, 16'hBEEF);
    run_commit("rstw.fresh", 4'b1001, 4'hF, 1'b1, 4'd9, 16'h5A5A, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule

// File: doc/cycle_config_scheduler.md
# cycle_config_scheduler

Sequences configuration writes into NUM_CHANNELS backend cycle controllers sharing one configuration bus. A host fills a 10-word shadow profile, then commits it to a channel mask. The scheduler optionally waits for each targeted channel to finish its update cycle, halts those channels' timers, streams the 10 config words (addresses 0x00–0x09), and restarts the timers. It sits between the host register interface and the per-channel cycle controllers.

## Interface
- NUM_CHANNELS, 4, number of backend cycle controllers driven
- CFG_WORDS, 10, profile length; fixed at 10 (config addresses 0x00–0x09)

- clock  in  1  system clock, all logic on rising edge
- reset_n  in  1  synchronous, active-low reset
- shadow_we  in  1  shadow profile write strobe
- shadow_addr  in  4  shadow word index 0–9; 10–15 ignored
- shadow_data  in  16  shadow word value
- shadow_err  out  1  sticky: shadow write dropped (busy or addr>9)
- run_enable  in  NUM_CHANNELS  host run request per channel
- commit_valid  in  1  commit request
- commit_mask  in  NUM_CHANNELS  channels targeted by the commit
- commit_ready  out  1  high only in IDLE
- commit_done  out  1  one-cycle pulse when a commit finishes
- busy  out  1  high in every state except IDLE
- update_cycle_complete  in  NUM_CHANNELS  per-channel ordering-complete status
- timer_enable  out  NUM_CHANNELS  per-channel timer enable
- write_config_n  out  NUM_CHANNELS  per-channel active-low config write strobe
- config_address  out  6  shared config address
- config_data  out  16  shared config data

## Operation
- Shadow: 10×16 registers. Write when shadow_we=1, busy=0, shadow_addr≤9. A write with busy=1 or shadow_addr>9 is dropped and sets shadow_err.
- timer_enable[i] = run_enable[i] & ~halted[i], registered. halted is set for masked channels in HALT and cleared in RESUME.
- States: IDLE, WAIT_SYNC, HALT, WRITE, RESUME.
  - IDLE: commit_valid&commit_ready latches commit_mask into tgt.
    - tgt==0: go to RESUME (no-op commit; commit_done still pulses).
    - Otherwise: go to WAIT_SYNC (or HALT, see Configuration).
  - WAIT_SYNC: channel i is synced if update_cycle_complete[i]=1 or timer_enable[i]=0. Leave for HALT when every tgt channel is synced.
  - HALT: timer_enable[tgt] driven 0; one cycle; go to WRITE with word counter=0.
  - WRITE: one word per cycle, 10 cycles.
    - write_config_n[tgt]=0; non-target channels stay 1.
    - config_address = counter; config_data = shadow[counter].
    - Counter 9 → RESUME.
  - RESUME: clear halted[tgt], pulse commit_done, go to IDLE.
- run_enable changes take effect on the next cycle for non-halted channels. Halted channels stay disabled until RESUME regardless of run_enable.
- Outside WRITE: write_config_n all 1; config_address and config_data hold their last values.

## Timing
- Reset values: timer_enable=0, write_config_n=all 1, config_address=0, config_data=0, commit_ready=0 during reset and 1 the cycle after, commit_done=0, busy=0, shadow_err=0, shadow=all 0, state=IDLE.
- Accept at edge T, sync already met: WAIT_SYNC cycle T+1, HALT T+2, WRITE T+3..T+12, RESUME T+13, IDLE (commit_ready=1) T+14.
- With CFG_SYNC_COMMIT_EN undefined, WAIT_SYNC is skipped and every step moves one cycle earlier (commit_ready=1 at T+13).
- A tgt==0 commit: RESUME at T+1, IDLE at T+2.
- timer_enable of tgt channels is 0 from HALT through the last WRITE cycle inclusive. It is 1 in RESUME if run_enable is set.
- A shadow write in the same cycle as a commit acceptance is applied before the profile is streamed.
- Reset asserted in any state returns all outputs to reset values on the next edge. A partially written profile is abandoned.

## Configuration
- CFG_SYNC_COMMIT_EN defined: WAIT_SYNC is present. A commit never interrupts a running channel before its update_cycle_complete.
- CFG_SYNC_COMMIT_EN undefined: WAIT_SYNC is removed; IDLE goes straight to HALT. update_cycle_complete is unused.

## Test plan
- Reset, then idle: timer_enable=0, write_config_n=4'hF, commit_ready=1, busy=0, shadow_err=0.
- Shadow words 0..9 = 16'h1000+i, run_enable=4'hF, commit mask=4'b0101, sync met:
  - write_config_n=4'b1010 for exactly 10 cycles, addresses 0..9, data 16'h1000..16'h1009.
  - timer_enable=4'b1010 during HALT/WRITE, 4'hF in RESUME, commit_done one pulse.
- CFG_SYNC_COMMIT_EN defined, mask=4'b0001, update_cycle_complete[0]=0 held for 20 cycles then 1:
  - Stays in WAIT_SYNC with timer_enable[0]=1.
  - HALT starts the cycle after the input rises.
- shadow_we during WRITE, and shadow_addr=12 while IDLE: shadow unchanged, shadow_err=1 until reset.
- commit_mask=0: commit_done pulses at T+1, commit_ready back at T+2, no write_config_n activity.
- reset_n=0 at the 5th WRITE cycle: next edge write_config_n=4'hF, timer_enable=0, state IDLE. A fresh commit then completes normally.
